// File: rtl/mem_array_writer_if.sv
// RAM-side bus of the array writer: registered address/data/write-enable out,
// read data back with one clock of latency.
interface mem_array_writer_if;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       mem_wren;
    logic [7:0] mem_q;

    modport master (output mem_addr, output mem_data, output mem_wren, input mem_q);
    modport slave  (input mem_addr, input mem_data, input mem_wren, output mem_q);
endinterface

// File: rtl/mem_array_writer.sv
// Tick-paced writer/checker: fills a 32x8 RAM with base + i*step, then reads
// every entry back and counts mismatches (saturating).
module mem_array_writer #(
    parameter int N        = 10,
    parameter int TICK_DIV = 25_000_000,
    parameter int VERIFY   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic [7:0]               base,
    input  logic [7:0]               step,
    input  logic                     disp_sel,
    mem_array_writer_if.master       mem,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               err_count,
    output logic [7:0]               disp_val
);
    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_INIT   = 4'd1;
    localparam logic [3:0] S_WCOND  = 4'd2;
    localparam logic [3:0] S_WRITE  = 4'd3;
    localparam logic [3:0] S_WINCR  = 4'd4;
    localparam logic [3:0] S_VADDR  = 4'd5;
    localparam logic [3:0] S_VWAIT  = 4'd6;
    localparam logic [3:0] S_VCHECK = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;
    localparam logic [3:0] S_ERROR  = 4'd9;

    localparam int         TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [5:0] N_LAST = 6'(N - 1);
    localparam logic [5:0] N_END  = 6'(N);

    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [3:0]    state;
    logic [5:0]    i;          // reaches N, so N=32 needs the sixth bit
    logic [7:0]    val;
    logic [7:0]    base_r;
    logic [7:0]    step_r;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tick_cnt <= '0;
        else
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            i            <= '0;
            val          <= '0;
            base_r       <= '0;
            step_r       <= '0;
            mem.mem_addr <= '0;
            mem.mem_data <= '0;
            mem.mem_wren <= 1'b0;
            err_count    <= '0;
        end else begin
            // Write strobe is a single clk wide regardless of tick rate
            if (mem.mem_wren)
                mem.mem_wren <= 1'b0;
            if (tick) begin
                case (state)
                    S_IDLE: if (go) state <= S_INIT;
                    S_INIT: begin
                        base_r    <= base;
                        step_r    <= step;
                        val       <= base;
                        i         <= '0;
                        err_count <= '0;
                        state     <= S_WCOND;
                    end
                    S_WCOND: begin
                        if (i < N_END) begin
                            mem.mem_addr <= i[4:0];
                            mem.mem_data <= val;
                            mem.mem_wren <= 1'b1;
                            state        <= S_WRITE;
                        end else if (VERIFY != 0) begin
                            i     <= '0;
                            val   <= base_r;
                            state <= S_VADDR;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                    S_WRITE: state <= S_WINCR;
                    S_WINCR: begin
                        i     <= i + 6'd1;
                        val   <= val + step_r;
                        state <= S_WCOND;
                    end
                    S_VADDR: begin
                        mem.mem_addr <= i[4:0];
                        state        <= S_VWAIT;
                    end
                    S_VWAIT: state <= S_VCHECK;
                    S_VCHECK: begin
                        if (mem.mem_q != val && err_count != 4'hF)
                            err_count <= err_count + 4'd1;
                        i     <= i + 6'd1;
                        val   <= val + step_r;
                        state <= (i == N_LAST) ? S_DONE : S_VADDR;
                    end
                    S_DONE: if (!go) state <= S_IDLE;
                    S_ERROR: begin
                        mem.mem_wren <= 1'b0;
                        state        <= S_IDLE;
                    end
                    default: begin
                        mem.mem_wren <= 1'b0;
                        state        <= S_ERROR;
                    end
                endcase
            end
        end
    end

    assign busy     = (state >= S_INIT) && (state <= S_VCHECK);
    assign done     = (state == S_DONE);
    assign disp_val = disp_sel ? {3'b000, i[4:0]} : {4'b0000, err_count};
endmodule

// File: tb/tb_mem_array_writer.sv
// Directed bench: three writer instances (N=10 verify, N=20 verify, N=10 no-verify
// at TICK_DIV=4) each on a behavioural 1-clk-latency RAM.
module tb_mem_array_writer;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] go_v = 3'b000;
    logic [7:0] base = 8'd0, step = 8'd0;
    logic       disp_sel = 1'b0;
    logic       busy0, busy1, busy2, done0, done1, done2;
    logic [3:0] err0, err1, err2;
    logic [7:0] disp0, disp1, disp2;
    bit         stuck4 = 1'b0, all_ff = 1'b0;
    int         cyc = 0, checks = 0, errors = 0, wide = 0;
    logic [2:0] pw = 3'b000;

    typedef struct { int c; logic [4:0] a; logic [7:0] d; } wr_t;
    wr_t wlog0[$], wlog2[$];

    typedef struct {
        logic [7:0] base, step;
        bit         stuck;
        logic [3:0] err;
        logic [7:0] d9;
    } vec_t;
    vec_t vt [5];

    mem_array_writer_if b0(), b1(), b2();

    mem_array_writer #(.N(10), .TICK_DIV(1), .VERIFY(1)) u0 (.clk(clk), .rst(rst), .go(go_v[0]),
        .base(base), .step(step), .disp_sel(disp_sel), .mem(b0), .busy(busy0), .done(done0),
        .err_count(err0), .disp_val(disp0));
    mem_array_writer #(.N(20), .TICK_DIV(1), .VERIFY(1)) u1 (.clk(clk), .rst(rst), .go(go_v[1]),
        .base(base), .step(step), .disp_sel(disp_sel), .mem(b1), .busy(busy1), .done(done1),
        .err_count(err1), .disp_val(disp1));
    mem_array_writer #(.N(10), .TICK_DIV(4), .VERIFY(0)) u2 (.clk(clk), .rst(rst), .go(go_v[2]),
        .base(base), .step(step), .disp_sel(disp_sel), .mem(b2), .busy(busy2), .done(done2),
        .err_count(err2), .disp_val(disp2));

    wire [2:0] busy_v = {busy2, busy1, busy0};
    wire [2:0] done_v = {done2, done1, done0};
    wire [2:0] wren_v = {b2.mem_wren, b1.mem_wren, b0.mem_wren};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] m0 [32], m1 [32], m2 [32];

    function automatic logic [7:0] ram_rd(input logic [7:0] d, input logic [4:0] a);
        return all_ff ? 8'hFF : (d | {7'b0, stuck4 && a == 5'd4});
    endfunction

    always @(posedge clk) begin
        if (b0.mem_wren) m0[b0.mem_addr] <= b0.mem_data;
        if (b1.mem_wren) m1[b1.mem_addr] <= b1.mem_data;
        if (b2.mem_wren) m2[b2.mem_addr] <= b2.mem_data;
        b0.mem_q <= ram_rd(m0[b0.mem_addr], b0.mem_addr);
        b1.mem_q <= ram_rd(m1[b1.mem_addr], b1.mem_addr);
        b2.mem_q <= ram_rd(m2[b2.mem_addr], b2.mem_addr);
    end

    always @(negedge clk) begin
        if (b0.mem_wren) wlog0.push_back('{cyc, b0.mem_addr, b0.mem_data});
        if (b2.mem_wren) wlog2.push_back('{cyc, b2.mem_addr, b2.mem_data});
        if (|(pw & wren_v)) wide <= wide + 1;
        pw <= wren_v;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Raise go, return tick count from sampling tick to DONE entry (inclusive).
    task automatic run(input int k, input int td, output int ticks);
        int t0, t1;
        t0 = -1; t1 = -1;
        @(negedge clk);
        go_v[k] = 1'b1;
        for (int n = 0; n < 5000 && t1 < 0; n++) begin
            @(posedge clk); #1;
            if (t0 < 0 && busy_v[k]) t0 = cyc;
            if (t0 >= 0 && done_v[k]) t1 = cyc;
        end
        chk("done_reached", t1 >= 0, 1);
        ticks = (t1 >= 0) ? (t1 - t0) / td + 1 : 0;
    endtask

    task automatic release_go(input int k);
        int n;
        @(negedge clk);
        go_v[k] = 1'b0;
        for (n = 0; n < 100 && done_v[k]; n++) @(negedge clk);
        chk("back_to_idle", {busy_v[k], done_v[k]}, 2'b00);
    endtask

    initial begin
        int t;
        vt[0] = '{8'd0,   8'd1,    1'b0, 4'd0, 8'd9};
        vt[1] = '{8'd250, 8'd3,    1'b0, 4'd0, 8'd21};
        vt[2] = '{8'd0,   8'd2,    1'b1, 4'd1, 8'd18};
        vt[3] = '{8'd7,   8'd0,    1'b1, 4'd0, 8'd7};
        vt[4] = '{8'h10,  8'h11,   1'b1, 4'd1, 8'hA9};

        #2;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_err", err0, 0);
        chk("rst_wren", b0.mem_wren, 0);
        chk("rst_addr", b0.mem_addr, 0);
        chk("rst_data", b0.mem_data, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        for (int v = 0; v < 5; v++) begin
            base = vt[v].base; step = vt[v].step; stuck4 = vt[v].stuck;
            wlog0.delete();
            run(0, 1, t);
            chk($sformatf("v%0d_ticks", v), t, 63);
            chk($sformatf("v%0d_nwr", v), wlog0.size(), 10);
            for (int j = 0; j < 10 && j < wlog0.size(); j++) begin
                chk($sformatf("v%0d_addr%0d", v, j), wlog0[j].a, j);
                chk($sformatf("v%0d_data%0d", v, j), wlog0[j].d, 8'(vt[v].base + j * vt[v].step));
            end
            if (wlog0.size() == 10) chk($sformatf("v%0d_last", v), wlog0[9].d, vt[v].d9);
            chk($sformatf("v%0d_err", v), err0, vt[v].err);
            chk($sformatf("v%0d_done", v), done0, 1);
            disp_sel = 1'b0; #1;
            chk($sformatf("v%0d_disp_err", v), disp0, {4'b0, vt[v].err});
            disp_sel = 1'b1; #1;
            chk($sformatf("v%0d_disp_i", v), disp0, 8'h0A);
            release_go(0);
        end
        if (wlog0.size() == 10) chk("wrap_d2", wlog0[2].d, 8'hA9 - 8'h99 + 8'h22);
        stuck4 = 1'b0;

        // Saturation: every read returns 0xFF against 0..19
        all_ff = 1'b1; base = 8'd0; step = 8'd1;
        run(1, 1, t);
        chk("sat_ticks", t, 123);
        chk("sat_err", err1, 4'hF);
        disp_sel = 1'b0; #1;
        chk("sat_disp", disp1, 8'h0F);
        release_go(1);
        all_ff = 1'b0;

        // Reset asserted while entry 5's write strobe is high
        base = 8'd0; step = 8'd1; wlog0.delete();
        @(negedge clk);
        go_v[0] = 1'b1;
        t = 0;
        for (int n = 0; n < 200 && t == 0; n++) begin
            @(posedge clk); #1;
            if (b0.mem_wren && b0.mem_addr == 5'd5) t = 1;
        end
        chk("mid_found", t, 1);
        rst = 1'b0; #1;
        chk("mid_wren", b0.mem_wren, 0);
        chk("mid_busy", busy0, 0);
        chk("mid_addr", b0.mem_addr, 0);
        chk("mid_data", b0.mem_data, 0);
        disp_sel = 1'b1; #1;
        chk("mid_disp", disp0, 0);
        go_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        wlog0.delete();
        run(0, 1, t);
        chk("rerun_ticks", t, 63);
        chk("rerun_nwr", wlog0.size(), 10);
        if (wlog0.size() > 0) chk("rerun_addr0", wlog0[0].a, 0);
        release_go(0);

        // Slow tick, no readback
        base = 8'd5; step = 8'd7; wlog2.delete();
        run(2, 4, t);
        chk("slow_ticks", t, 33);
        chk("slow_nwr", wlog2.size(), 10);
        if (wlog2.size() >= 2) chk("slow_spacing", wlog2[1].c - wlog2[0].c, 12);
        if (wlog2.size() == 10) chk("slow_last", wlog2[9].d, 8'd68);
        chk("slow_disp_i", disp2, 8'h0A);
        release_go(2);
        wlog2.delete();
        run(2, 4, t);
        chk("slow2_ticks", t, 33);
        chk("slow2_err", err2, 0);
        chk("slow2_nwr", wlog2.size(), 10);
        release_go(2);

        chk("wren_width", wide, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
